// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arbiter_if: port A / port B request buses plus memory-side bus |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32
);
  logic                  a_req,    b_req;
  logic                  a_we,     b_we;
  logic [ADDR_WIDTH-1:0] a_addr,   b_addr;
  logic [DATA_WIDTH-1:0] a_wdata,  b_wdata;
  logic                  a_gnt,    b_gnt;
  logic                  a_rvalid, b_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata,  b_rdata;
  logic                  mem_en_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [DATA_WIDTH-1:0] mem_data_out;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  mem_data_out,
    output a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
    output mem_en_write, mem_addr, mem_data_in
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output mem_data_out,
    input  a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
    input  mem_en_write, mem_addr, mem_data_in
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arbiter: two requesters (A fetch, B load-store) sharing one    |
// | combinational-read memory, one access per two cycles.              |
// | MEM_ARBITER_ROUND_ROBIN_EN: alternate on contention, else B wins.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic    clk,
  input  wire logic    reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_t                state_q, state_d;
  logic                  cmd_we_q, cmd_we_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic                  last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
  logic                  a_gnt_q, a_gnt_d;
  logic                  b_gnt_q, b_gnt_d;
  logic                  a_rvalid_q, a_rvalid_d;
  logic                  b_rvalid_q, b_rvalid_d;
  logic                  mem_en_write_q, mem_en_write_d;
  logic                  any_req;
  logic                  pick_b;

  always_comb begin
    any_req = bus.a_req | bus.b_req;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    pick_b  = bus.b_req & (~bus.a_req | (last_grant_q == PORT_A));
`else
    pick_b  = bus.b_req;
`endif
  end

  always_comb begin
    state_d        = state_q;
    cmd_we_d       = cmd_we_q;
    cmd_addr_d     = cmd_addr_q;
    cmd_wdata_d    = cmd_wdata_q;
    last_grant_d   = last_grant_q;
    a_rdata_d      = a_rdata_q;
    b_rdata_d      = b_rdata_q;
    a_gnt_d        = 1'b0;
    b_gnt_d        = 1'b0;
    a_rvalid_d     = 1'b0;
    b_rvalid_d     = 1'b0;
    mem_en_write_d = 1'b0;
    case (state_q)
      ISSUE: begin
        // Memory is being driven this cycle; capture read data at its end.
        state_d = RESP;
        if (last_grant_q == PORT_B) begin
          b_rvalid_d = 1'b1;
          if (!cmd_we_q) b_rdata_d = bus.mem_data_out;
        end else begin
          a_rvalid_d = 1'b1;
          if (!cmd_we_q) a_rdata_d = bus.mem_data_out;
        end
      end
      default: begin
        if (any_req) begin
          state_d        = ISSUE;
          last_grant_d   = pick_b ? PORT_B : PORT_A;
          cmd_we_d       = pick_b ? bus.b_we    : bus.a_we;
          cmd_addr_d     = pick_b ? bus.b_addr  : bus.a_addr;
          cmd_wdata_d    = pick_b ? bus.b_wdata : bus.a_wdata;
          mem_en_write_d = cmd_we_d;
          a_gnt_d        = ~pick_b;
          b_gnt_d        = pick_b;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cmd_we_q       <= 1'b0;
      cmd_addr_q     <= '0;
      cmd_wdata_q    <= '0;
      last_grant_q   <= PORT_B;
      a_rdata_q      <= '0;
      b_rdata_q      <= '0;
      a_gnt_q        <= 1'b0;
      b_gnt_q        <= 1'b0;
      a_rvalid_q     <= 1'b0;
      b_rvalid_q     <= 1'b0;
      mem_en_write_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_we_q       <= cmd_we_d;
      cmd_addr_q     <= cmd_addr_d;
      cmd_wdata_q    <= cmd_wdata_d;
      last_grant_q   <= last_grant_d;
      a_rdata_q      <= a_rdata_d;
      b_rdata_q      <= b_rdata_d;
      a_gnt_q        <= a_gnt_d;
      b_gnt_q        <= b_gnt_d;
      a_rvalid_q     <= a_rvalid_d;
      b_rvalid_q     <= b_rvalid_d;
      mem_en_write_q <= mem_en_write_d;
    end
  end

  assign bus.a_gnt        = a_gnt_q;
  assign bus.b_gnt        = b_gnt_q;
  assign bus.a_rvalid     = a_rvalid_q;
  assign bus.b_rvalid     = b_rvalid_q;
  assign bus.a_rdata      = a_rdata_q;
  assign bus.b_rdata      = b_rdata_q;
  assign bus.mem_en_write = mem_en_write_q;
  assign bus.mem_addr     = cmd_addr_q;
  assign bus.mem_data_in  = cmd_wdata_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_arbiter: randomized scoreboard bench for mem_arbiter        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mem_arbiter;
  localparam int AW        = 30;
  localparam int DW        = 32;
  localparam int MEM_WORDS = 64;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic init_en = 1'b1;
  int   total   = 0;
  int   bad     = 0;
  int   cyc     = 0;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return 32'hA5A5_0000 | 32'(i * 257);
  endfunction

  // Environment memory: combinational read, write on the clock edge.
  logic [DW-1:0] env_mem [MEM_WORDS];
  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < MEM_WORDS; i++) env_mem[i] <= init_word(i);
    end else if (bus.mem_en_write) begin
      env_mem[bus.mem_addr[5:0]] <= bus.mem_data_in;
    end
  end
  assign bus.mem_data_out = env_mem[bus.mem_addr[5:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int            due;
    logic          port;
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
  } exp_t;

  exp_t          sbq [$];
  logic [DW-1:0] ref_mem [MEM_WORDS];
  logic [DW-1:0] exp_rd [2];
  logic          model_last;
  logic [AW-1:0] model_cmd_addr;
  int            last_gnt;

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
    exp_rd[0] = '0; exp_rd[1] = '0;
    model_last = 1'b1; model_cmd_addr = '0; last_gnt = -100;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_a_gnt",    bus.a_gnt, 0);
        chk("rst_b_gnt",    bus.b_gnt, 0);
        chk("rst_a_rvalid", bus.a_rvalid, 0);
        chk("rst_b_rvalid", bus.b_rvalid, 0);
        chk("rst_mem_we",   bus.mem_en_write, 0);
        chk("rst_a_rdata",  bus.a_rdata, 0);
        chk("rst_b_rdata",  bus.b_rdata, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        sbq.delete();
        exp_rd[0] = '0; exp_rd[1] = '0;
        model_last = 1'b1; model_cmd_addr = '0; last_gnt = -100;
      end else begin
        logic          exp_rv, exp_g, w, we_w;
        logic [AW-1:0] addr_w;
        logic [DW-1:0] wd_w;
        exp_t          e;
        exp_rv = (sbq.size() > 0) && (sbq[0].due == cyc);
        chk("rvalid_any",  bus.a_rvalid | bus.b_rvalid, exp_rv);
        chk("rvalid_excl", bus.a_rvalid & bus.b_rvalid, 0);
        if (exp_rv) begin
          e = sbq.pop_front();
          chk("rvalid_port", bus.b_rvalid, e.port);
          chk("a_rdata", bus.a_rdata, e.ra);
          chk("b_rdata", bus.b_rdata, e.rb);
        end
        // One grant per two cycles whenever anyone is asking.
        exp_g = (bus.a_req | bus.b_req) && (last_gnt != cyc - 1);
        chk("gnt_any",  bus.a_gnt | bus.b_gnt, exp_g);
        chk("gnt_excl", bus.a_gnt & bus.b_gnt, 0);
        if (exp_g) begin
          if (bus.a_req && bus.b_req) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            w = ~model_last;
`else
            w = 1'b1;
`endif
          end else begin
            w = bus.b_req;
          end
          chk("gnt_winner", bus.b_gnt, w);
          we_w   = w ? bus.b_we    : bus.a_we;
          addr_w = w ? bus.b_addr  : bus.a_addr;
          wd_w   = w ? bus.b_wdata : bus.a_wdata;
          chk("issue_we",   bus.mem_en_write, we_w);
          chk("issue_addr", bus.mem_addr, addr_w);
          if (we_w) begin
            chk("issue_wdata", bus.mem_data_in, wd_w);
            ref_mem[addr_w[5:0]] = wd_w;
          end else begin
            exp_rd[w] = ref_mem[addr_w[5:0]];
          end
          sbq.push_back('{due: cyc + 1, port: w, ra: exp_rd[0], rb: exp_rd[1]});
          model_last = w; last_gnt = cyc; model_cmd_addr = addr_w;
        end else begin
          chk("idle_mem_we",   bus.mem_en_write, 0);
          chk("hold_mem_addr", bus.mem_addr, model_cmd_addr);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_port(input logic p, input logic req, input logic we,
                          input int addr, input logic [DW-1:0] wd);
    if (p) begin
      bus.b_req = req; bus.b_we = we; bus.b_addr = AW'(addr); bus.b_wdata = wd;
    end else begin
      bus.a_req = req; bus.a_we = we; bus.a_addr = AW'(addr); bus.a_wdata = wd;
    end
  endtask

  task automatic rand_port(input logic p);
    set_port(p, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, MEM_WORDS - 1)), $urandom);
  endtask

  function automatic logic get_req(input logic p);
    return p ? bus.b_req : bus.a_req;
  endfunction

  function automatic logic get_gnt(input logic p);
    return p ? bus.b_gnt : bus.a_gnt;
  endfunction

  task automatic do_txn(input logic p, input logic we, input int addr, input logic [DW-1:0] wd);
    logic seen = 1'b0;
    set_port(p, 1'b1, we, addr, wd);
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = get_gnt(p);
    end
    chk("gnt_seen", seen, 1);
    set_port(p, 1'b0, 1'b0, 0, '0);
  endtask

  initial begin
    int   ngnt;
    logic seen;
    set_port(1'b0, 1'b0, 1'b0, 0, '0);
    set_port(1'b1, 1'b0, 1'b0, 0, '0);
    repeat (3) tick();
    rst = 1'b0; init_en = 1'b0;
    repeat (10) tick();

    // Single read from A
    do_txn(1'b0, 1'b0, 'h10, '0);
    tick();
    chk("dir_a_rvalid", bus.a_rvalid, 1);
    chk("dir_a_rdata",  bus.a_rdata, 32'hDEADBEEF);
    chk("dir_b_idle",   bus.b_rvalid | bus.b_gnt, 0);

    // B write then A read-back
    do_txn(1'b1, 1'b1, 'h20, 32'h12345678);
    chk("dir_wr_en",   bus.mem_en_write, 1);
    chk("dir_wr_addr", bus.mem_addr, 'h20);
    tick();
    chk("dir_b_rvalid", bus.b_rvalid, 1);
    chk("dir_wr_off",   bus.mem_en_write, 0);
    do_txn(1'b0, 1'b0, 'h20, '0);
    tick();
    chk("dir_readback", bus.a_rdata, 32'h12345678);

    // Reset during the ISSUE cycle of a write
    set_port(1'b1, 1'b1, 1'b1, 'h30, 32'hCAFEF00D);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = bus.b_gnt;
    end
    chk("rst_issue_gnt", seen, 1);
    rst = 1'b1;
    set_port(1'b1, 1'b0, 1'b0, 0, '0);
    tick();
    rst = 1'b0;
    chk("rst_issue_we",     bus.mem_en_write, 0);
    chk("rst_issue_rvalid", bus.b_rvalid, 0);
    repeat (4) tick();

    // Both ports requesting continuously
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rand_port(1'b0); rand_port(1'b1);
    ngnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.a_gnt) begin ngnt++; rand_port(1'b0); end
      if (bus.b_gnt) begin ngnt++; rand_port(1'b1); end
    end
    chk("both_gnt_rate", ngnt, 20);
    set_port(1'b1, 1'b0, 1'b0, 0, '0);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      seen = bus.a_gnt;
    end
    chk("a_after_b_drop", seen, 1);
    set_port(1'b0, 1'b0, 1'b0, 0, '0);
    repeat (3) tick();

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      tick();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      for (int p = 0; p < 2; p++) begin
        if (get_req(1'(p)) && get_gnt(1'(p))) begin
          if ($urandom_range(0, 1) == 1) rand_port(1'(p));
          else set_port(1'(p), 1'b0, 1'b0, 0, '0);
        end else if (!get_req(1'(p)) && $urandom_range(0, 2) == 0) begin
          rand_port(1'(p));
        end
      end
    end

    rst = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, 0, '0);
    set_port(1'b1, 1'b0, 1'b0, 0, '0);
    repeat (6) tick();
    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 30, word-address width on all ports.
REQ-002 Parameter DATA_WIDTH, default 32, data width on all ports.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 a_req, b_req  input  1 each  access request from port A (fetch) / port B (load-store).
REQ-006 a_we, b_we  input  1 each  1 = write, 0 = read.
REQ-007 a_addr, b_addr  input  ADDR_WIDTH each  word address.
REQ-008 a_wdata, b_wdata  input  DATA_WIDTH each  write data.
REQ-009 a_gnt, b_gnt  output  1 each  one-cycle grant pulse.
REQ-010 a_rvalid, b_rvalid  output  1 each  one-cycle completion pulse.
REQ-011 a_rdata, b_rdata  output  DATA_WIDTH each  read data, valid with rvalid.
REQ-012 mem_en_write  output  1  memory write enable.
REQ-013 mem_addr  output  ADDR_WIDTH  memory address.
REQ-014 mem_data_in  output  DATA_WIDTH  memory write data.
REQ-015 mem_data_out  input  DATA_WIDTH  memory read data, combinational from mem_addr.

Function
REQ-016 FSM states IDLE, ISSUE, RESP; one access per ISSUE state.
REQ-017 IDLE or RESP with any req high: latch winner's we/addr/wdata into command registers, go to ISSUE; else go to IDLE.
REQ-018 ISSUE: drive mem_addr/mem_data_in from command registers; mem_en_write = latched we; winner's gnt = 1; go to RESP.
REQ-019 End of ISSUE: capture mem_data_out into winner's rdata register (reads only); rdata of the other port unchanged.
REQ-020 RESP: winner's rvalid = 1 for exactly one cycle; for writes rvalid acknowledges completion and rdata holds its previous value.
REQ-021 Latency: req sampled at edge N -> gnt in cycle N+1 -> rvalid/rdata in cycle N+2; back-to-back throughput one access per 2 cycles.
REQ-022 Requester holds req/we/addr/wdata stable until it sees gnt; req still high in the cycle after gnt is a new request.
REQ-023 mem_en_write = 0 in IDLE and RESP; mem_addr/mem_data_in hold last command register value outside ISSUE.
REQ-024 Only one req high: that port wins regardless of arbitration policy.
REQ-025 last_grant register records the winner of each latched command.
REQ-026 At most one of a_gnt/b_gnt and at most one of a_rvalid/b_rvalid high in any cycle.

Reset
REQ-027 reset high at an edge: state = IDLE, command registers = 0, last_grant = B, a_rdata = b_rdata = 0.
REQ-028 During and after reset: all gnt, rvalid and mem_en_write = 0.
REQ-029 Reset in ISSUE or RESP abandons the access; no rvalid is issued for it.
REQ-030 reset overrides any simultaneous req.

Configuration
REQ-031 Macro MEM_ARBITER_ROUND_ROBIN_EN defined: when both req are high, winner is the port not recorded in last_grant.
REQ-032 Macro undefined: when both req are high, port B always wins; last_grant still updated, not used.

Verification
REQ-033 Reset, then a_req=1, a_we=0, a_addr=0x10, memory[0x10]=0xDEADBEEF -> a_gnt in cycle 1, a_rvalid with a_rdata=0xDEADBEEF in cycle 2, b outputs idle.
REQ-034 b_req write addr=0x20 wdata=0x12345678 -> mem_en_write=1, mem_addr=0x20 for exactly the ISSUE cycle; b_rvalid next cycle; later read of 0x20 returns 0x12345678.
REQ-035 Both req held continuously, ROUND_ROBIN_EN defined -> grants alternate A,B,A,B, first to A after reset, one gnt every 2 cycles.
REQ-036 Both req held, macro undefined -> B granted every 2 cycles, A never granted until b_req drops, then A granted in next ISSUE.
REQ-037 reset asserted in ISSUE cycle of a write to 0x30 -> no rvalid, mem_en_write = 0 from next cycle, state IDLE.
REQ-038 a_req and b_req both 0 for 10 cycles -> FSM stays IDLE, no gnt, rvalid or mem_en_write.
